// File: rtl/sd_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : sd_upsampler
// Purpose  : Linear-interpolating upsampler feeding a first-order sigma-delta
//            DAC. Ramps from the previous target to each newly accepted signed
//            sample over 2^RATIO_LOG2 clocks. The output is offset-binary.
// Revision : 1.0 - initial release
// ============================================================================
module sd_upsampler #(
   parameter int N          = 16,
   parameter int RATIO_LOG2 = 2
) (
   input  logic         clk,
   input  logic         n_reset,
   input  logic [N-1:0] sample_in,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic [N-1:0] pcm_out,
   output logic         busy
);

   // Accumulator width: integer part plus RATIO_LOG2 fraction bits
   localparam int AW = N + RATIO_LOG2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RAMP = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic signed [AW-1:0]  acc_q, acc_d;
   logic signed [N-1:0]   tgt_q, tgt_d;
   logic signed [N:0]     delta_q, delta_d;
   logic                  last;
   logic                  accept;
   logic        [N-1:0]   acc_int;

   assign sample_ready = (state_q == IDLE) || last;
   assign accept       = sample_valid && sample_ready;
   assign busy         = (state_q == RAMP);

   // Arithmetic shift right by RATIO_LOG2 (floor) then flip the MSB for offset-binary
   assign acc_int = acc_q[AW-1:RATIO_LOG2];
   assign pcm_out = {~acc_int[N-1], acc_int[N-2:0]};

   generate
      if (RATIO_LOG2 > 0) begin : g_cnt
         logic [RATIO_LOG2-1:0] cnt_q, cnt_d;

         // Step counter: restarts on accept, advances on every ramp clock
         always_comb begin
            cnt_d = cnt_q;
            if (accept) begin
               cnt_d = '0;
            end else if (state_q == RAMP) begin
               cnt_d = cnt_q + RATIO_LOG2'(1);
            end
         end

         // Step counter register
         always_ff @(posedge clk or negedge n_reset) begin
            if (!n_reset) begin
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_d;
            end
         end

         assign last = (state_q == RAMP) && (cnt_q == '1);
      end else begin : g_no_cnt
         // A one-clock ramp: every ramp cycle is the final one
         assign last = (state_q == RAMP);
      end
   endgenerate

   // Next-state and datapath: step the accumulator, latch a new target on accept
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      tgt_d   = tgt_q;
      delta_d = delta_q;

      // The closing step of a ramp still lands even when a new sample is taken
      if (state_q == RAMP) begin
         acc_d = acc_q + AW'(delta_q);
      end

      if (accept) begin
         // Difference against the previous target keeps every ramp landing exactly
         delta_d = $signed({sample_in[N-1], sample_in}) - $signed({tgt_q[N-1], tgt_q});
         tgt_d   = sample_in;
         state_d = RAMP;
      end else if (last) begin
         state_d = IDLE;
      end
   end

   // State and datapath registers with asynchronous clear to midscale
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         tgt_q   <= '0;
         delta_q <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         tgt_q   <= tgt_d;
         delta_q <= delta_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sd_upsampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_upsampler
// Purpose  : Directed self-checking bench for sd_upsampler (R=2 and R=0 builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_upsampler;

   logic        clk;
   logic        n_reset;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic [15:0] pcm_out;
   logic        busy;

   logic [15:0] sample_in0;
   logic        sample_valid0;
   logic        sample_ready0;
   logic [15:0] pcm_out0;
   logic        busy0;

   int tests_run;
   int tests_failed;

   sd_upsampler #(.N(16), .RATIO_LOG2(2)) u_dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .pcm_out      (pcm_out),
      .busy         (busy)
   );

   sd_upsampler #(.N(16), .RATIO_LOG2(0)) u_dut0 (
      .clk          (clk),
      .n_reset      (n_reset),
      .sample_in    (sample_in0),
      .sample_valid (sample_valid0),
      .sample_ready (sample_ready0),
      .pcm_out      (pcm_out0),
      .busy         (busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(posedge clk);
      #3;
      n_reset = 1'b0;
      #1;
      tests_run++;
      if (pcm_out !== 16'h8000) begin
         tests_failed++;
         $display("FAIL reset_pcm: got %h expected %h", pcm_out, 16'h8000);
      end
      tests_run++;
      if (sample_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 1", sample_ready);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_busy: got %b expected 0", busy);
      end
      tests_run++;
      if (pcm_out0 !== 16'h8000) begin
         tests_failed++;
         $display("FAIL reset_pcm_r0: got %h expected %h", pcm_out0, 16'h8000);
      end
      @(negedge clk);
      n_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single();
      logic [15:0] exp_pcm;
      sample_valid = 1'b1;
      sample_in    = 16'h0400;
      @(negedge clk);
      sample_valid = 1'b0;
      tests_run++;
      if (busy !== 1'b1 || pcm_out !== 16'h8000) begin
         tests_failed++;
         $display("FAIL single_accept: busy=%b pcm=%h expected busy=1 pcm=8000", busy, pcm_out);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp_pcm = 16'h8000 + 16'(k * 16'h0100);
         tests_run++;
         if (pcm_out !== exp_pcm) begin
            tests_failed++;
            $display("FAIL single_pcm step %0d: got %h expected %h", k, pcm_out, exp_pcm);
         end
         tests_run++;
         if (busy !== (k < 4)) begin
            tests_failed++;
            $display("FAIL single_busy step %0d: got %b expected %b", k, busy, (k < 4));
         end
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if (pcm_out !== 16'h8400 || sample_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_hold: pcm=%h ready=%b expected pcm=8400 ready=1", pcm_out, sample_ready);
         end
      end
   endtask

   task automatic test_swing();
      logic [15:0] exp_seq [4];
      exp_seq = '{16'hBFFF, 16'h7FFF, 16'h3FFF, 16'h0000};
      sample_valid = 1'b1;
      sample_in    = 16'h7FFF;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
      tests_run++;
      if (pcm_out !== 16'hFFFF || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL swing_settle: pcm=%h busy=%b expected pcm=ffff busy=0", pcm_out, busy);
      end
      sample_valid = 1'b1;
      sample_in    = 16'h8000;
      @(negedge clk);
      sample_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         tests_run++;
         if (pcm_out !== exp_seq[k]) begin
            tests_failed++;
            $display("FAIL swing_pcm step %0d: got %h expected %h", k + 1, pcm_out, exp_seq[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] smp [3];
      logic [15:0] exp_seq [12];
      logic        exp_busy;
      logic        exp_ready;
      smp     = '{16'h0100, 16'h0200, 16'h0100};
      exp_seq = '{16'h8040, 16'h8080, 16'h80C0, 16'h8100,
                  16'h8140, 16'h8180, 16'h81C0, 16'h8200,
                  16'h81C0, 16'h8180, 16'h8140, 16'h8100};
      // Start from midscale with a zero target
      n_reset = 1'b0;
      @(negedge clk);
      n_reset = 1'b1;
      sample_valid = 1'b1;
      sample_in    = smp[0];
      tests_run++;
      if (sample_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_first_ready: got %b expected 1", sample_ready);
      end
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1 || sample_ready !== 1'b0 || pcm_out !== 16'h8000) begin
         tests_failed++;
         $display("FAIL b2b_accept: busy=%b ready=%b pcm=%h expected 1 0 8000", busy, sample_ready, pcm_out);
      end
      for (int i = 0; i < 3; i++) begin
         for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            exp_busy  = !(i == 2 && k == 4);
            exp_ready = (k == 3) || (i == 2 && k == 4);
            tests_run++;
            if (pcm_out !== exp_seq[i*4 + k - 1] || busy !== exp_busy || sample_ready !== exp_ready) begin
               tests_failed++;
               $display("FAIL b2b ramp %0d step %0d: pcm=%h busy=%b ready=%b expected pcm=%h busy=%b ready=%b",
                        i, k, pcm_out, busy, sample_ready, exp_seq[i*4 + k - 1], exp_busy, exp_ready);
            end
            if (k == 3) begin
               if (i < 2) begin
                  sample_in = smp[i + 1];
               end else begin
                  sample_valid = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic test_reset_mid_ramp();
      logic [15:0] exp_pcm;
      sample_valid = 1'b1;
      sample_in    = 16'h1000;
      @(negedge clk);
      sample_valid = 1'b0;
      @(posedge clk);
      #2;
      n_reset = 1'b0;
      #1;
      tests_run++;
      if (pcm_out !== 16'h8000 || busy !== 1'b0 || sample_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midramp_reset: pcm=%h busy=%b ready=%b expected 8000 0 1", pcm_out, busy, sample_ready);
      end
      @(negedge clk);
      n_reset = 1'b1;
      sample_valid = 1'b1;
      sample_in    = 16'h0004;
      @(negedge clk);
      sample_valid = 1'b0;
      tests_run++;
      if (pcm_out !== 16'h8000) begin
         tests_failed++;
         $display("FAIL midramp_restart: got %h expected 8000", pcm_out);
      end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         exp_pcm = 16'h8000 + 16'(k);
         tests_run++;
         if (pcm_out !== exp_pcm) begin
            tests_failed++;
            $display("FAIL midramp_pcm step %0d: got %h expected %h", k, pcm_out, exp_pcm);
         end
      end
   endtask

   task automatic test_ratio0();
      logic [15:0] model_pcm;
      logic [15:0] pend;
      logic        pend_v;
      model_pcm = 16'h8000;
      pend      = 16'h0000;
      pend_v    = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 30; c++) begin
         tests_run++;
         if (sample_ready0 !== 1'b1 || pcm_out0 !== model_pcm) begin
            tests_failed++;
            $display("FAIL r0 cycle %0d: ready=%b pcm=%h expected ready=1 pcm=%h",
                     c, sample_ready0, pcm_out0, model_pcm);
         end
         if (pend_v) begin
            model_pcm = {~pend[15], pend[14:0]};
         end
         sample_valid0 = (c < 3) ? 1'b1 : 1'($urandom_range(0, 1));
         sample_in0    = 16'($urandom);
         pend_v        = sample_valid0;
         pend          = sample_in0;
         @(negedge clk);
      end
      sample_valid0 = 1'b0;
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      n_reset       = 1'b1;
      sample_in     = 16'h0000;
      sample_valid  = 1'b0;
      sample_in0    = 16'h0000;
      sample_valid0 = 1'b0;
      test_reset();
      test_single();
      test_swing();
      test_back_to_back();
      test_reset_mid_ramp();
      test_ratio0();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sd_upsampler.md
Name: sd_upsampler

Overview:
Upstream feeder for the first-order sigma-delta DAC stage. It accepts signed audio samples from the voice/filter path over a valid/ready handshake. It linearly interpolates from the previous sample to the new one over 2^RATIO_LOG2 clocks. It drives the DAC's unsigned offset-binary input on every clock, so the modulator never sees step discontinuities at the sample rate.

Parameters:
N, 16, sample and output width in bits; must match the downstream DAC width.
RATIO_LOG2, 2, log2 of the interpolation length in clocks; legal range 0..8.

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
sample_in  input  N  signed two's-complement sample
sample_valid  input  1  sample_in is valid this cycle
sample_ready  output  1  block accepts sample_in this cycle
pcm_out  output  N  unsigned offset-binary sample to the DAC
busy  output  1  interpolation ramp in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is n_reset, asynchronous and active-low.
- Registers and their reset values:
  - state: IDLE
  - acc: 0. Signed, N+RATIO_LOG2 bits, fixed point with RATIO_LOG2 fraction bits.
  - tgt: 0. Signed, N bits; holds the last accepted target.
  - delta: 0. Signed, N+1 bits.
  - cnt: 0. RATIO_LOG2 bits; for RATIO_LOG2=0, cnt is treated as constantly 0.
- Derived values:
  - acc_int = acc[N+RATIO_LOG2-1:RATIO_LOG2], which is floor(acc / 2^RATIO_LOG2).
  - pcm_out = {~acc_int[N-1], acc_int[N-2:0]}. pcm_out depends only on registers; there is no combinational path from the inputs.
  - last = (state==RAMP) && (cnt == 2^RATIO_LOG2-1).
  - sample_ready = (state==IDLE) || last.
  - busy = (state==RAMP).
- Outputs after reset: pcm_out = 2^(N-1) (midscale, 0x8000 for N=16), sample_ready=1, busy=0.
- Accept event: accept = sample_valid && sample_ready. On accept:
  - delta <= sample_in - tgt. The subtraction is computed at N+1 bits and is always against tgt, never against acc_int.
  - tgt <= sample_in
  - cnt <= 0
  - state <= RAMP
- RAMP, each clock:
  - acc <= acc + delta (sign-extended)
  - cnt <= cnt+1
- RAMP exit: on the last cycle, state <= IDLE unless accept occurs in the same cycle, in which case state stays RAMP with the new delta and cnt=0. The final step of the old ramp is still applied on that edge.
- Exact landing: after exactly 2^RATIO_LOG2 RAMP edges, acc = tgt<<RATIO_LOG2 exactly. Ramps always complete, so acc never accumulates error and no saturation logic is needed.
- Intermediate values truncate toward negative infinity (floor).
- Latency: the first pcm_out change is one clock after the accept edge. pcm_out equals the target 2^RATIO_LOG2 edges after accept.
- Maximum throughput: one sample per 2^RATIO_LOG2 clocks, via back-to-back accepts on last cycles.
- RATIO_LOG2=0: every RAMP cycle is last, so sample_ready stays 1 and pcm_out follows sample_in with one cycle of latency.
- IDLE with no valid input: hold acc; pcm_out keeps its value (underrun holds the last sample).
- Zero delta: an accepted sample equal to tgt still runs a full ramp; pcm_out is unchanged throughout.
- sample_valid while not ready: ignored. The sender must hold sample_valid/sample_in until accepted.
- n_reset asserted mid-ramp: all registers clear immediately and pcm_out returns to midscale asynchronously. Operation restarts in IDLE after reset release.

Test Plan:
1. Reset, N=16, R=2: assert n_reset low mid-clock -> pcm_out=0x8000, sample_ready=1, busy=0 without waiting for a clock edge.
2. Single sample 0x0400 -> pcm_out 0x8100, 0x8200, 0x8300, 0x8400 on the 4 edges after accept; busy high for 4 cycles; then hold at 0x8400 in IDLE.
3. Full-scale swing: settle at 0x7FFF, then send 0x8000 (-32768) -> pcm_out 0xBFFF, 0x7FFF, 0x3FFF, 0x0000 (checks floor truncation and the 17-bit delta).
4. Back-to-back: hold sample_valid high with 0x0100, 0x0200, 0x0100 -> accepts spaced exactly 4 clocks apart; pcm_out continuous and monotonic within each ramp; busy never drops; sample_ready pulses only on last cycles.
5. Reset mid-ramp: assert n_reset on the 2nd ramp cycle -> pcm_out=0x8000 immediately; after release, sample 0x0004 ramps from midscale to 0x8004.
6. RATIO_LOG2=0 build: random valid stream -> sample_ready constantly 1; pcm_out = offset-binary of sample_in delayed one clock.
